// File: rtl/data_connection_block.sv
// data_connection_block: unidirectional connection block on a vertical W-track
// routing channel. Each logic-block input bit taps one north- or south-bound
// track, and each outgoing track either passes the opposite track through or
// carries a logic-block output bit. A configuration word latched into cfg
// decides all routing; the routing itself is combinational.
// Optional build macro: DCB_OUT_REG_EN registers north_out, south_out and
// data_input (one extra cycle of latency, async-cleared to 0).
module data_connection_block #(
  parameter int W       = 16,
  parameter int WW      = 4,
  parameter int DATAIN  = 4,
  parameter int DATAOUT = 3,
  localparam int NGRP        = 2 * W / WW,
  localparam int SEL_PER_IN  = $clog2(NGRP),
  localparam int SEL_PER_OUT = $clog2(DATAOUT + 1),
  localparam int OB          = SEL_PER_IN * DATAIN * WW,
  localparam int CW          = OB + SEL_PER_OUT * 2 * W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cset,
  input  logic [CW-1:0]         c,
  input  logic [W-1:0]          north_in,
  input  logic [W-1:0]          south_in,
  output logic [W-1:0]          north_out,
  output logic [W-1:0]          south_out,
  input  logic [WW*DATAOUT-1:0] data_output,
  output logic [WW*DATAIN-1:0]  data_input
);

  // Index widths for the variable bit selects into tracks and output words.
  localparam int TW = $clog2(W);
  localparam int DW = $clog2(WW * DATAOUT);

  logic [CW-1:0]        cfg;
  logic [W-1:0]         nout_c;
  logic [W-1:0]         sout_c;
  logic [WW*DATAIN-1:0] din_c;

  // Configuration register: loads c on cset, otherwise holds.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)      cfg <= '0;
    else if (cset) cfg <= c;
  end

  // Input pins: even selector picks a north track group, odd picks south;
  // bit j of the word always comes from bit j of the chosen group.
  for (genvar n = 0; n < DATAIN * WW; n++) begin : g_in
    logic [SEL_PER_IN-1:0] sel;
    logic [TW-1:0]         idx;
    assign sel = cfg[n*SEL_PER_IN +: SEL_PER_IN];
    assign idx = TW'((int'(sel) >> 1) * WW + n % WW);
    assign din_c[n] = (int'(sel) >= NGRP) ? 1'b0 :
                      sel[0]              ? south_in[idx] : north_in[idx];
  end

  // Outgoing tracks: selector 0 (or out of range) passes the opposite track
  // through; 1..DATAOUT picks that output word, bit t%WW.
  for (genvar t = 0; t < W; t++) begin : g_out
    logic [SEL_PER_OUT-1:0] kn, ks;
    logic [DW-1:0]          idx_n, idx_s;
    assign kn    = cfg[OB + (2*t)*SEL_PER_OUT   +: SEL_PER_OUT];
    assign ks    = cfg[OB + (2*t+1)*SEL_PER_OUT +: SEL_PER_OUT];
    assign idx_n = DW'((int'(kn) - 1) * WW + t % WW);
    assign idx_s = DW'((int'(ks) - 1) * WW + t % WW);
    assign nout_c[t] = (kn != '0 && int'(kn) <= DATAOUT) ? data_output[idx_n] : south_in[t];
    assign sout_c[t] = (ks != '0 && int'(ks) <= DATAOUT) ? data_output[idx_s] : north_in[t];
  end

`ifdef DCB_OUT_REG_EN
  // Registered outputs: one cycle behind the combinational routing.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      north_out  <= '0;
      south_out  <= '0;
      data_input <= '0;
    end else begin
      north_out  <= nout_c;
      south_out  <= sout_c;
      data_input <= din_c;
    end
  end
`else
  assign north_out  = nout_c;
  assign south_out  = sout_c;
  assign data_input = din_c;
`endif

endmodule

// File: tb/tb_data_connection_block.sv
// Testbench for data_connection_block: directed vector table, multi-cycle
// hold/reset sequences, and randomized stimulus against a behavioural model.
module tb_data_connection_block;
  localparam int W = 16, WW = 4, DATAIN = 4, DATAOUT = 3;
  localparam int SPI = 3, SPO = 2, OB = 48, CW = 112;
`ifdef DCB_OUT_REG_EN
  localparam bit REG_OUT = 1'b1;
`else
  localparam bit REG_OUT = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  rst, cset;
  logic [CW-1:0]         c;
  logic [W-1:0]          north_in, south_in, north_out, south_out;
  logic [WW*DATAOUT-1:0] data_output;
  logic [WW*DATAIN-1:0]  data_input;

  int checks = 0;
  int failures = 0;

  data_connection_block dut (
    .clk(clk), .rst(rst), .cset(cset), .c(c),
    .north_in(north_in), .south_in(south_in),
    .north_out(north_out), .south_out(south_out),
    .data_output(data_output), .data_input(data_input)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Configuration word builders.
  function automatic logic [CW-1:0] set_in(input logic [CW-1:0] cw, input int n, input int k);
    logic [CW-1:0] r;
    r = cw;
    r[n*SPI +: SPI] = k[SPI-1:0];
    return r;
  endfunction

  function automatic logic [CW-1:0] set_out(input logic [CW-1:0] cw, input int t, input int south, input int k);
    logic [CW-1:0] r;
    r = cw;
    r[OB + (2*t + south)*SPO +: SPO] = k[SPO-1:0];
    return r;
  endfunction

  // Behavioural model, straight from the routing rules.
  function automatic int field(input logic [CW-1:0] cf, input int lsb, input int width);
    logic [CW-1:0] s;
    s = cf >> lsb;
    return int'(s[7:0]) % (1 << width);
  endfunction

  function automatic logic [15:0] m_di(input logic [CW-1:0] cf, input logic [15:0] ni, input logic [15:0] si);
    logic [15:0] r;
    logic [15:0] src;
    int k;
    r = '0;
    for (int n = 0; n < DATAIN*WW; n++) begin
      k = field(cf, n*SPI, SPI);
      if (k < 2*W/WW) begin
        src = (k % 2 == 1) ? si : ni;
        r[n] = src[(k/2)*WW + n%WW];
      end
    end
    return r;
  endfunction

  function automatic logic [15:0] m_track(input logic [CW-1:0] cf, input int south,
                                          input logic [15:0] pass, input logic [11:0] d);
    logic [15:0] r;
    int k;
    for (int t = 0; t < W; t++) begin
      k = field(cf, OB + (2*t + south)*SPO, SPO);
      r[t] = (k >= 1 && k <= DATAOUT) ? d[(k-1)*WW + t%WW] : pass[t];
    end
    return r;
  endfunction

  typedef struct {
    string         name;
    logic [CW-1:0] cw;
    logic [15:0]   ni, si;
    logic [11:0]   d;
    logic [15:0]   eno, eso, edi;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [CW-1:0] cw, input logic [15:0] ni,
                         input logic [15:0] si, input logic [11:0] d, input logic [15:0] eno,
                         input logic [15:0] eso, input logic [15:0] edi);
    vec_t v;
    v.name = nm; v.cw = cw; v.ni = ni; v.si = si; v.d = d;
    v.eno = eno; v.eso = eso; v.edi = edi;
    vecs.push_back(v);
  endtask

  // Load a config word with matching data inputs, then wait out the latency.
  task automatic apply_cfg(input logic [CW-1:0] cw, input logic [15:0] ni,
                           input logic [15:0] si, input logic [11:0] d);
    cset = 1'b1; c = cw; north_in = ni; south_in = si; data_output = d;
    @(posedge clk); #1;
    cset = 1'b0;
    repeat (int'(REG_OUT)) begin @(posedge clk); #1; end
  endtask

  logic [CW-1:0] mcfg;
  logic [127:0]  rnd;
  logic [15:0]   pre_no, pre_so, pre_di;
  logic [CW-1:0] zc;

  initial begin
    zc = '0;
    add_vec("reset_cfg",   zc, 16'hA5C3, 16'h3C5A, 12'h000, 16'h3C5A, 16'hA5C3, 16'h3333);
    add_vec("in0_k3",      set_in(zc, 0, 3), 16'h0000, 16'h00F0, 12'h000, 16'h00F0, 16'h0000, 16'h0001);
    add_vec("in0_4_k6_a",  set_in(set_in(zc, 0, 6), 4, 6), 16'h0100, 16'h0000, 12'h000, 16'h0000, 16'h0100, 16'h0000);
    add_vec("in0_4_k6_b",  set_in(set_in(zc, 0, 6), 4, 6), 16'h1100, 16'h0000, 12'h000, 16'h0000, 16'h1100, 16'h0011);
    add_vec("no5_k2",      set_out(zc, 5, 0, 2), 16'h0000, 16'h0000, 12'hFA0, 16'h0020, 16'h0000, 16'h0000);
    add_vec("no5_k0",      zc, 16'h0000, 16'h0000, 12'hFA0, 16'h0000, 16'h0000, 16'h0000);
    add_vec("so15_k3",     set_out(zc, 15, 1, 3), 16'h0000, 16'h0000, 12'h800, 16'h0000, 16'h8000, 16'h0000);
    add_vec("in1_k7",      set_in(zc, 1, 7), 16'h0000, 16'h2000, 12'h000, 16'h2000, 16'h0000, 16'h0002);
    add_vec("in15_k1",     set_in(zc, 15, 1), 16'h0000, 16'h0008, 12'h000, 16'h0008, 16'h0000, 16'h8000);
    add_vec("so2k1_no7k3", set_out(set_out(zc, 2, 1, 1), 7, 0, 3), 16'h0000, 16'h0000, 12'h804, 16'h0080, 16'h0004, 16'h0000);

    // Reset state.
    rst = 1'b0; cset = 1'b1; c = '0;
    north_in = 16'hA5C3; south_in = 16'h3C5A; data_output = '0;
    #3;
    check("rst_north_out",  32'(north_out),  REG_OUT ? 32'h0 : 32'h3C5A);
    check("rst_south_out",  32'(south_out),  REG_OUT ? 32'h0 : 32'hA5C3);
    check("rst_data_input", 32'(data_input), REG_OUT ? 32'h0 : 32'h3333);
    #9 rst = 1'b1;

    // Directed table.
    foreach (vecs[i]) begin
      apply_cfg(vecs[i].cw, vecs[i].ni, vecs[i].si, vecs[i].d);
      check({vecs[i].name, "_no"}, 32'(north_out),  32'(vecs[i].eno));
      check({vecs[i].name, "_so"}, 32'(south_out),  32'(vecs[i].eso));
      check({vecs[i].name, "_di"}, 32'(data_input), 32'(vecs[i].edi));
    end

    // Config holds while cset is low, then updates on the next loading edge.
    apply_cfg(set_out(zc, 5, 0, 2), 16'h0000, 16'h1200, 12'hFA0);
    check("hold_initial", 32'(north_out), 32'h1220);
    c = '0;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk); #1;
      check($sformatf("hold_edge%0d", e), 32'(north_out), 32'h1220);
    end
    cset = 1'b1;
    @(posedge clk); #1;
    cset = 1'b0;
    repeat (int'(REG_OUT)) begin @(posedge clk); #1; end
    check("reload_no", 32'(north_out), 32'h1200);

    // Asynchronous reset mid-run, no clock edge involved.
    apply_cfg(set_out(set_in(zc, 0, 5), 15, 1, 3), 16'h25C3, 16'h3C5A, 12'h800);
    check("pre_arst_so", 32'(south_out), 32'hA5C3);
    #2 rst = 1'b0;
    #1;
    check("arst_no", 32'(north_out),  REG_OUT ? 32'h0 : 32'h3C5A);
    check("arst_so", 32'(south_out),  REG_OUT ? 32'h0 : 32'h25C3);
    check("arst_di", 32'(data_input), REG_OUT ? 32'h0 : 32'h3333);
    @(negedge clk) rst = 1'b1;

    // Randomized stimulus against the model.
    mcfg = '0;
    for (int it = 0; it < 100; it++) begin
      rnd = {$urandom, $urandom, $urandom, $urandom};
      c = rnd[CW-1:0];
      north_in = 16'($urandom);
      south_in = 16'($urandom);
      data_output = 12'($urandom);
      cset = ($urandom % 4) != 0;
      pre_no = m_track(mcfg, 0, south_in, data_output);
      pre_so = m_track(mcfg, 1, north_in, data_output);
      pre_di = m_di(mcfg, north_in, south_in);
      @(posedge clk);
      if (cset) mcfg = c;
      #1;
      check($sformatf("rnd%0d_no", it), 32'(north_out),
            REG_OUT ? 32'(pre_no) : 32'(m_track(mcfg, 0, south_in, data_output)));
      check($sformatf("rnd%0d_so", it), 32'(south_out),
            REG_OUT ? 32'(pre_so) : 32'(m_track(mcfg, 1, north_in, data_output)));
      check($sformatf("rnd%0d_di", it), 32'(data_input),
            REG_OUT ? 32'(pre_di) : 32'(m_di(mcfg, north_in, south_in)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
